jt1943_rom_loader: RTL

//  Sits between hps_io's ioctl byte stream and jtgng_sdram/jt1943_game during ROM download.

---
 rtl/jt1943_rom_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/jt1943_rom_loader.sv
// ROM download router: splits the hps_io ioctl byte stream into SDRAM writes
// (prog_* handshake, one byte of buffering) and single-cycle on-chip PROM writes.
module jt1943_rom_loader #(
    parameter logic [24:0] PROM_START = 25'h2_0000,
    parameter int          PROM_AW    = 11,
    parameter int          SDRAM_AW   = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    input  logic                prog_ack,
    output logic                prog_we,
    output logic [SDRAM_AW-1:0] prog_addr,
    output logic [7:0]          prog_data,
    output logic [1:0]          prog_mask,
    output logic                prom_we,
    output logic [PROM_AW-1:0]  prom_addr,
    output logic [7:0]          prom_data,
    output logic                loop_rst,
    output logic                rom_ready,
    output logic                overflow
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state;
    logic                is_prom;
    logic                sdram_wr;
    logic [24:0]         prom_off;
    logic [SDRAM_AW-1:0] in_addr;
    logic [1:0]          in_mask;
    logic                buf_full;
    logic [SDRAM_AW-1:0] buf_addr;
    logic [7:0]          buf_data;
    logic [1:0]          buf_mask;
    logic                dl_last;
    logic                loading;
    logic                unused_addr_bits;

    assign is_prom  = ioctl_addr >= PROM_START;
    assign sdram_wr = ioctl_wr & ~is_prom;
    assign prom_off = ioctl_addr - PROM_START;
    // Upper address bits wrap on the SDRAM path; the mask is active-low per byte lane.
    assign in_addr  = ioctl_addr[SDRAM_AW:1];
    assign in_mask  = ioctl_addr[0] ? 2'b01 : 2'b10;
    assign unused_addr_bits = ^{ioctl_addr[24:SDRAM_AW+1], prom_off[24:PROM_AW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '0;
            prom_we   <= 1'b0;
            prom_addr <= '0;
            prom_data <= '0;
            buf_full  <= 1'b0;
            loop_rst  <= 1'b1;
            rom_ready <= 1'b0;
            overflow  <= 1'b0;
            dl_last   <= 1'b0;
            loading   <= 1'b0;
        end else begin
            dl_last  <= downloading;
            loop_rst <= downloading | prog_we | buf_full;

            prom_we <= ioctl_wr & is_prom;
            if (ioctl_wr & is_prom) begin
                prom_addr <= prom_off[PROM_AW-1:0];
                prom_data <= ioctl_data;
            end

            // rom_ready only follows a download that actually started after reset.
            if (downloading & ~dl_last) begin
                rom_ready <= 1'b0;
                overflow  <= 1'b0;
                loading   <= 1'b1;
            end else if (loading & ~loop_rst) begin
                rom_ready <= 1'b1;
                loading   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sdram_wr) begin
                        prog_addr <= in_addr;
                        prog_data <= ioctl_data;
                        prog_mask <= in_mask;
                        prog_we   <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Ack is handled before a same-cycle byte, so that byte never overflows.
                    if (prog_ack) begin
                        if (buf_full) begin
                            prog_addr <= buf_addr;
                            prog_data <= buf_data;
                            prog_mask <= buf_mask;
                            if (sdram_wr) begin
                                buf_addr <= in_addr;
                                buf_data <= ioctl_data;
                                buf_mask <= in_mask;
                            end else begin
                                buf_full <= 1'b0;
                            end
                        end else if (sdram_wr) begin
                            prog_addr <= in_addr;
                            prog_data <= ioctl_data;
                            prog_mask <= in_mask;
                        end else begin
                            prog_we <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (sdram_wr) begin
                        if (buf_full) begin
                            overflow <= 1'b1;
                        end else begin
                            buf_addr <= in_addr;
                            buf_data <= ioctl_data;
                            buf_mask <= in_mask;
                            buf_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
